// File: rtl/p2s_tx_if.sv
// Parallel word handshake and serial line bundle for p2s_tx.
// The master side is the word source/line monitor; the slave side is the transmitter.
interface p2s_tx_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dout;
  logic             sof;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, dout, sof, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, dout, sof, busy
  );
endinterface

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter with a one-word holding register, LSB first by default.
// Define P2S_MSB_FIRST_EN to send each word MSB first instead.
module p2s_tx #(
  parameter int WIDTH = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  p2s_tx_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_vld_q, hold_vld_d;
  logic             dout_q, dout_d;
  logic             sof_q, sof_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             accept;
  logic             load;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sh_next;

  assign bus.din_ready = !hold_vld_q;
  assign bus.dout      = dout_q;
  assign bus.sof       = sof_q;
  assign bus.busy      = busy_q;

  // No same-edge refill: a full hold blocks acceptance even on its drain edge.
  assign accept = bus.din_valid && !hold_vld_q;

`ifdef P2S_MSB_FIRST_EN
  assign first_bit = hold_q[WIDTH-1];
  assign next_bit  = sh_q[WIDTH-2];
  assign sh_next   = {sh_q[WIDTH-2:0], 1'b0};
`else
  assign first_bit = hold_q[0];
  assign next_bit  = sh_q[1];
  assign sh_next   = {1'b0, sh_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_vld_d = hold_vld_q;
    sh_d       = sh_q;
    dout_d     = 1'b0;
    sof_d      = 1'b0;
    busy_d     = 1'b0;
    load       = 1'b0;

    if (accept) begin
      hold_vld_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        load = hold_vld_q;
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          cnt_d  = cnt_q + 1'b1;
          sh_d   = sh_next;
          dout_d = next_bit;
          busy_d = 1'b1;
        end else if (hold_vld_q) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    // Reload from hold is identical from IDLE and at the last bit, so frames abut.
    if (load) begin
      state_d    = SHIFT;
      sh_d       = hold_q;
      dout_d     = first_bit;
      sof_d      = 1'b1;
      busy_d     = 1'b1;
      cnt_d      = '0;
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      dout_q     <= 1'b0;
      sof_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      dout_q     <= dout_d;
      sof_q      <= sof_d;
      busy_q     <= busy_d;
    end
  end

  // Word payloads need no reset; hold_vld and state qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_q <= bus.din;
    end
    sh_q <= sh_d;
  end

endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: frame-schedule reference model plus a deserialiser loopback.
module tb_p2s_tx;
  localparam int W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  p2s_tx_if #(.WIDTH(W)) bus ();
  p2s_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  bit accepted;

  // Reference: each accepted word gets a start edge; bit k is on the line after start+k.
  int             fr_acc[$];
  int             fr_start[$];
  logic [W-1:0]   fr_word[$];
  logic [W-1:0]   rx_exp[$];
  logic [W-1:0]   rx_word;
  int             rx_cnt;
  bit             rx_on;

  function automatic logic exp_bit(logic [W-1:0] w, int k);
`ifdef P2S_MSB_FIRST_EN
    return w[W-1-k];
`else
    return w[k];
`endif
  endfunction

  function automatic bit model_ready();
    foreach (fr_acc[i])
      if (fr_acc[i] <= edge_n && edge_n < fr_start[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, expv, edge_n);
    end
  endtask

  task automatic model_accept(logic [W-1:0] w);
    int s;
    s = edge_n + 1;
    if (fr_start.size() > 0 && fr_start[$] + W > s) s = fr_start[$] + W;
    fr_acc.push_back(edge_n);
    fr_start.push_back(s);
    fr_word.push_back(w);
    rx_exp.push_back(w);
  endtask

  task automatic model_clear();
    fr_acc.delete();
    fr_start.delete();
    fr_word.delete();
    rx_exp.delete();
    rx_on = 1'b0;
  endtask

  task automatic check_line();
    logic e_dout, e_sof, e_busy;
    e_dout = 1'b0; e_sof = 1'b0; e_busy = 1'b0;
    foreach (fr_start[i]) begin
      if (fr_start[i] <= edge_n && edge_n < fr_start[i] + W) begin
        e_busy = 1'b1;
        e_sof  = (edge_n == fr_start[i]);
        e_dout = exp_bit(fr_word[i], edge_n - fr_start[i]);
      end
    end
    chk("dout", 32'(bus.dout), 32'(e_dout));
    chk("sof", 32'(bus.sof), 32'(e_sof));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("din_ready", 32'(bus.din_ready), 32'(model_ready()));
  endtask

  task automatic deser();
    logic [W-1:0] expw;
    if (bus.sof) begin
      rx_on   = 1'b1;
      rx_cnt  = 0;
      rx_word = '0;
    end
    if (rx_on && bus.busy) begin
`ifdef P2S_MSB_FIRST_EN
      rx_word[W-1-rx_cnt] = bus.dout;
`else
      rx_word[rx_cnt] = bus.dout;
`endif
      rx_cnt++;
      if (rx_cnt == W) begin
        rx_on = 1'b0;
        expw  = 'x;
        if (rx_exp.size() > 0) expw = rx_exp.pop_front();
        chk("rx_word", 32'(rx_word), 32'(expw));
      end
    end
  endtask

  task automatic cycle();
    bit           acc;
    logic [W-1:0] w;
    acc = rst_n && bus.din_valid && model_ready();
    w   = bus.din;
    @(posedge clk);
    edge_n++;
    if (acc) model_accept(w);
    accepted = acc;
    while (fr_start.size() > 0 && fr_start[0] + W <= edge_n) begin
      void'(fr_acc.pop_front());
      void'(fr_start.pop_front());
      void'(fr_word.pop_front());
    end
    #1;
    check_line();
    deser();
  endtask

  task automatic send(logic [W-1:0] w, output int ncyc);
    bus.din       = w;
    bus.din_valid = 1'b1;
    ncyc = 0;
    do begin
      cycle();
      ncyc++;
    end while (!accepted && ncyc < 50);
    chk("send_accepted", 32'(accepted), 32'd1);
  endtask

  task automatic idle(int n);
    bus.din_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    int n;
    logic [W-1:0] w;
    rx_on = 1'b0;
    bus.din = 10'h2B5;
    bus.din_valid = 1'b1;

    // Reset held over three edges with a word offered: nothing may be accepted.
    repeat (3) cycle();
    rst_n = 1'b1;

    // Single word right after reset release; accepted on the first edge.
    send(10'h2B5, n);
    chk("first_accept_cycles", 32'(n), 32'd1);
    idle(W + 3);

    // Back-to-back frames with valid held throughout.
    send(10'h3FF, n);
    send(10'h000, n);
    idle(2 * W + 3);

    // Backpressure: three words queued behind a single-entry hold.
    send(10'h001, n);
    send(10'h002, n);
    send(10'h004, n);
    idle(3 * W + 3);

    // Reset mid-word with a second word waiting in hold.
    send(10'h155, n);
    send(10'h0AA, n);
    idle(2);
    chk("busy_before_reset", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("dout_async_reset", 32'(bus.dout), 32'd0);
    chk("busy_async_reset", 32'(bus.busy), 32'd0);
    chk("sof_async_reset", 32'(bus.sof), 32'd0);
    chk("ready_async_reset", 32'(bus.din_ready), 32'd1);
    model_clear();
    idle(2);
    rst_n = 1'b1;
    send(10'h3C3, n);
    idle(W + 3);

    // Random stream: mix of back-to-back words and idle gaps of various lengths.
    for (int i = 0; i < 1000; i++) begin
      w = W'($urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
      send(w, n);
    end
    idle(2 * W + 4);

    chk("rx_all_received", 32'(rx_exp.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/p2s_tx.md
Name: p2s_tx

Overview:
- Parallel-to-serial transmitter: accepts WIDTH-bit words over a valid/ready handshake and serialises them one bit per clk, LSB first.
- A one-word holding register lets back-to-back words stream with no idle bit between frames. A word boundary therefore falls exactly every WIDTH cycles, matching the team's 10-bit deserialiser framing.
- Sits between the parallel datapath and the serial line driver.

Parameters:
- WIDTH, 10, serial word length in bits (>=2); also the bit-counter range 0..WIDTH-1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data, registered.
- sof  output  1  registered; high during the cycle dout carries bit 0 of a word.
- busy  output  1  registered; high while dout carries word bits.

Behaviour:
- Interface fixed: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (rst_n low, asynchronous):
  - dout=0, sof=0, busy=0, hold_vld=0, bit counter=0, state IDLE.
  - Any partial word and any held word are discarded.
  - din_ready=1 as soon as hold_vld clears.
- Handshake:
  - din_ready = !hold_vld (combinational from register).
  - Transfer occurs on an edge where din_valid && din_ready; din is copied to hold, hold_vld<=1.
  - din_valid while din_ready=0 is ignored; the source must keep din stable.
- Holding register: exactly one entry, with no same-edge refill. While hold_vld=1, din_ready=0 even on the edge hold drains. Ready returns the cycle after the drain.
- Shift register sh[WIDTH-1:0] and bit counter cnt (clog2(WIDTH) bits). States: IDLE, SHIFT.
- IDLE:
  - hold_vld=1: at next edge, sh<=hold, dout<=hold[0], sof<=1, busy<=1, cnt<=0, hold_vld<=0, go SHIFT.
  - Otherwise: dout=0, sof=0, busy=0.
- SHIFT, cnt<WIDTH-1: each edge cnt<=cnt+1, dout<=next bit (sh shifted right), sof<=0.
- SHIFT, cnt==WIDTH-1 (last bit on line):
  - hold_vld=1: reload exactly as from IDLE (sof<=1, cnt<=0), stay SHIFT. No gap between frames.
  - Otherwise: go IDLE, dout<=0, busy<=0, sof<=0.
- Latency: word accepted at edge N puts bit k on dout after edge N+1+k, k=0..WIDTH-1. This assumes the line was idle, or the previous frame ends by N+1.
- Throughput: one word per WIDTH cycles sustained. A source that answers ready within WIDTH-2 cycles never causes a gap.
- Counter never exceeds WIDTH-1; wrap to 0 only on reload.
- Reset asserted mid-word: dout drops to 0 immediately (asynchronous). Next accepted word transmits complete from bit 0.

Optional Feature:
- P2S_MSB_FIRST_EN defined:
  - Load puts hold[WIDTH-1] on dout first.
  - sh shifts left; bit WIDTH-1-k appears after edge N+1+k.
  - sof still marks the first bit of the frame.
- Undefined: LSB first as above (default, matches the deserialiser).

Test Plan:
- Reset: hold rst_n=0 over 3 edges with din_valid=1 -> dout=0, sof=0, busy=0, din_ready=1 throughout, no word accepted. Release -> first word accepted at the next edge.
- Single word, WIDTH=10:
  - din=10'h2B5 accepted at edge N -> dout after edges N+1..N+10 = 1,0,1,0,1,1,0,1,0,1.
  - sof high only after N+1; busy high 10 cycles.
  - dout=0, busy=0 after N+11.
- Back-to-back: 10'h3FF then 10'h000 with din_valid held -> 20 contiguous bits (ten 1s, ten 0s), sof after N+1 and N+11, busy never drops between frames.
- Backpressure: din_valid held high with words 10'h001, 10'h002, 10'h004 -> din_ready=0 while hold full. Each word transmitted exactly once, in order, with no gaps.
- Reset mid-word: assert rst_n after 4 bits of 10'h155 with 10'h0AA held -> dout=0 immediately, busy=0, held word dropped. After release, 10'h3C3 sends all 10 bits intact.
- Loopback: random 1000-word stream into a 10-bit LSB-first deserialiser model aligned on sof -> every received word equals the sent word. Repeat with P2S_MSB_FIRST_EN and an MSB-first model.
